sc_key_sw_conditioner: RTL

Input-conditioning stage upstream of the single-cycle computer's data memory I/O ports. Raw DE1 push-buttons and slide switches are asynchronous and bouncy, so this block synchronises and debounces them. It presents clean switch and key levels, and it latches key-press events in sticky pending bits. The CPU fetches and clears those bits through a one-cycle read strobe issued by the data memory's I/O decoder.

---
 rtl/sc_io_pkg.sv | 16 +
 rtl/sc_debounce_bit.sv | 61 ++++++
 rtl/sc_key_sw_conditioner.sv | 95 +++++++++
 3 files changed

// File: rtl/sc_io_pkg.sv
// Shared constants for the key/switch input conditioner.
// Used by sc_debounce_bit and sc_key_sw_conditioner (see SC_IO_SW_DEBOUNCE_EN there).
package sc_io_pkg;

  localparam int   SC_IO_DEBOUNCE_DEFAULT = 500000;
  localparam int   SC_IO_NKEYS            = 3;
  localparam int   SC_IO_NSW              = 10;
  localparam logic SC_IO_KEY_IDLE         = 1'b1;
  localparam logic SC_IO_SW_IDLE          = 1'b0;

  // Counter width that holds DEBOUNCE_CYCLES-1, never narrower than one bit.
  function automatic int sc_cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sc_debounce_bit.sv
// One input bit: 2-flop synchroniser, consecutive-difference counter and
// accepted (stable) level with single-cycle rise/fall acceptance pulses.
module sc_debounce_bit
  import sc_io_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = SC_IO_DEBOUNCE_DEFAULT,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int              CW       = sc_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_ZERO = CW'(0);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic [CW-1:0] cnt_r;
  logic          accept_s;

  // Two-flop synchroniser for the asynchronous raw input.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r <= RESET_LEVEL;
      sync2_r <= RESET_LEVEL;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
    end
  end

  // The DEBOUNCE_CYCLES-th differing cycle is the one that commits the new level.
  assign accept_s = (sync2_r != stable_r) && (cnt_r == CNT_LAST);

  // Difference counter and accepted level; the counter clears on acceptance so it never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r    <= CNT_ZERO;
      stable_r <= RESET_LEVEL;
    end else if (sync2_r == stable_r) begin
      cnt_r    <= CNT_ZERO;
    end else if (accept_s) begin
      cnt_r    <= CNT_ZERO;
      stable_r <= sync2_r;
    end else begin
      cnt_r    <= cnt_r + CNT_ONE;
    end
  end

  assign stable = stable_r;
  assign rise   = accept_s & sync2_r;
  assign fall   = accept_s & ~sync2_r;

endmodule

// File: rtl/sc_key_sw_conditioner.sv
// Debounced DE1 keys/switches with sticky key-press pending bits and read-and-clear.
// Optional macro SC_IO_SW_DEBOUNCE_EN: when defined switches are debounced too, else only synchronised.
module sc_key_sw_conditioner
  import sc_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SC_IO_DEBOUNCE_DEFAULT,
  parameter int NKEYS           = SC_IO_NKEYS,
  parameter int NSW             = SC_IO_NSW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_raw,
  input  logic [NSW-1:0]   sw_raw,
  input  logic             rd_press,
  output logic [NKEYS-1:0] key_level,
  output logic [NSW-1:0]   sw_level,
  output logic [NKEYS-1:0] press_rdata,
  output logic             irq
);

  logic [NKEYS-1:0] key_stable_s;
  logic [NKEYS-1:0] key_fall_s;
  logic [NKEYS-1:0] key_rise_unused_s;
  logic [NSW-1:0]   sw_stable_s;
  logic [NKEYS-1:0] pend_r;
  logic [NKEYS-1:0] press_rdata_r;

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    sc_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (SC_IO_KEY_IDLE)
    ) u_key (
      .clock  (clock),
      .reset  (reset),
      .din    (key_raw[i]),
      .stable (key_stable_s[i]),
      .rise   (key_rise_unused_s[i]),
      .fall   (key_fall_s[i])
    );
  end

`ifdef SC_IO_SW_DEBOUNCE_EN
  logic [NSW-1:0] sw_rise_unused_s;
  logic [NSW-1:0] sw_fall_unused_s;

  for (genvar j = 0; j < NSW; j++) begin : g_sw
    sc_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (SC_IO_SW_IDLE)
    ) u_sw (
      .clock  (clock),
      .reset  (reset),
      .din    (sw_raw[j]),
      .stable (sw_stable_s[j]),
      .rise   (sw_rise_unused_s[j]),
      .fall   (sw_fall_unused_s[j])
    );
  end
`else
  logic [NSW-1:0] sw_sync1_r;
  logic [NSW-1:0] sw_sync2_r;

  // Switch synchroniser only; slide switches are trusted not to need debouncing here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_sync1_r <= {NSW{SC_IO_SW_IDLE}};
      sw_sync2_r <= {NSW{SC_IO_SW_IDLE}};
    end else begin
      sw_sync1_r <= sw_raw;
      sw_sync2_r <= sw_sync1_r;
    end
  end

  assign sw_stable_s = sw_sync2_r;
`endif

  // Sticky press bits; a read hands them over and keeps only presses landing on the read edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_r        <= {NKEYS{1'b0}};
      press_rdata_r <= {NKEYS{1'b0}};
    end else if (rd_press) begin
      press_rdata_r <= pend_r;
      pend_r        <= key_fall_s;
    end else begin
      pend_r        <= pend_r | key_fall_s;
    end
  end

  assign key_level   = ~key_stable_s;
  assign sw_level    = sw_stable_s;
  assign press_rdata = press_rdata_r;
  assign irq         = |pend_r;

endmodule
